barker_corr_sched: RTL and testbench
====================================

Name: barker_corr_sched

Overview:
- Frame-level scheduler that shares one correlation_barker datapath between N_REQ 1-bit AXI-Stream requesters.
- Grants one whole frame (up to the s_tlast beat) at a time, round-robin, and forwards it to the correlator.
- Waits for the correlator's single-beat result, then returns it tagged with the requester index.
- Sits between the framing/deserialiser front-ends and the correlator; provides timeout and overlength protection.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_LEN, 16, maximum beats per frame forwarded to the correlator (>=11).
- TIMEOUT, 16, cycles allowed in WAIT_RES before aborting (>=4).
- IDW, max(1,$clog2(N_REQ)), width of the requester index.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- s_tdata  in  N_REQ  per-requester data bit.
- s_tvalid  in  N_REQ  per-requester valid.
- s_tlast  in  N_REQ  per-requester end of frame.
- s_tready  out  N_REQ  per-requester ready.
- corr_tdata  out  1  to correlator s_tdata.
- corr_tvalid  out  1  to correlator s_tvalid.
- corr_tlast  out  1  to correlator s_tlast.
- corr_tready  in  1  from correlator s_tready.
- res_tuser  in  1  correlator m_tuser (1 = pattern match).
- res_tvalid  in  1  correlator m_tvalid.
- res_tready  out  1  to correlator m_tready.
- m_tuser  out  1  result bit.
- m_terr  out  1  result invalid (timeout).
- m_tid  out  IDW  requester index of the result.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream ready.
- o_busy  out  1  high in any state except IDLE.
- o_overlen  out  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Behaviour:
- Reset (async assert, sync-released internally by flop clear): state=IDLE, grant=0, rr pointer=N_REQ-1, beat counter=0, timeout counter=0. All outputs 0: s_tready, corr_*, res_tready, m_tuser, m_terr, m_tid, m_tvalid, o_busy, o_overlen. Reset mid-frame abandons the frame; no result is produced.
- States: IDLE, XFER, DRAIN, WAIT_RES, DELIVER.
- IDLE:
  - Request vector = s_tvalid.
  - Round-robin search starts at pointer+1, modulo N_REQ.
  - Winner registered as grant; next cycle enters XFER.
  - No request: stay in IDLE.
- XFER:
  - Combinational pass-through from the granted requester: corr_tdata=s_tdata[g], corr_tvalid=s_tvalid[g], s_tready[g]=corr_tready. All other s_tready=0.
  - res_tready=1, which keeps the correlator's input ready high.
  - Beat counter increments on corr_tvalid&corr_tready.
  - corr_tlast = s_tlast[g] | (count==MAX_LEN-1).
  - On an accepted beat with s_tlast[g]: go to WAIT_RES.
  - On an accepted beat with count==MAX_LEN-1 and !s_tlast[g]: pulse o_overlen, go to DRAIN.
- DRAIN:
  - s_tready[g]=1, corr_tvalid=0, res_tready=1; accepted beats are discarded.
  - On a beat with s_tlast[g]: go to WAIT_RES.
  - A result arriving during DRAIN is captured and delivered after drain completes.
- WAIT_RES:
  - res_tready=1; timeout counter increments every cycle.
  - res_tvalid: capture res_tuser into m_tuser, m_terr=0, go to DELIVER.
  - Counter reaching TIMEOUT-1 with no res_tvalid: m_tuser=0, m_terr=1, go to DELIVER.
  - Simultaneous result and timeout: the result wins.
- DELIVER:
  - m_tvalid=1, m_tid=g; outputs held stable until m_tready.
  - res_tready=0, all s_tready=0.
  - On m_tready: pointer=g, counters cleared, go to IDLE.
- res_tvalid in IDLE or DELIVER (stray) is ignored and not accepted.
- Latency:
  - Grant to first forwarded beat: 1 cycle.
  - Last beat to result: correlator latency (2 cycles) + 1.
  - Back-to-back frames: minimum 1 IDLE cycle between frames.
- o_busy = (state != IDLE), registered.

Test Plan:
- Single frame: requester 0 sends 11100010010 with tlast on bit 11 -> one m_tvalid with m_tuser=1, m_terr=0, m_tid=0; then state IDLE.
- Non-match: requester 1 sends 11100010011 -> m_tuser=0, m_tid=1.
- Round-robin: N_REQ=4, requesters 0 and 2 continuously valid from reset -> grant order 0,2,0,2; m_tid sequence 0,2,0,2; no requester starved.
- Overlength: MAX_LEN=16, requester 3 sends a 20-beat frame -> corr_tlast on beat 16; o_overlen pulses once; 4 beats drained with corr_tvalid=0; one result for m_tid=3.
- Timeout: res_tvalid forced 0, TIMEOUT=16 -> m_tvalid 16 cycles after entering WAIT_RES, with m_terr=1, m_tuser=0.
- Backpressure and reset: hold m_tready=0 for 5 cycles in DELIVER -> m_tvalid/m_tid/m_tuser stable, all s_tready=0; separately, assert i_rst_n=0 mid-XFER -> all outputs 0 immediately, no result after release.

Source files
------------

// File: rtl/barker_corr_sched_if.sv
// Stream bundle between the requesters, the shared correlator and the result consumer.
// The slave modport is the scheduler's view; the master modport is the surrounding environment.
interface barker_corr_sched_if #(
   parameter int N_REQ = 4,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0] s_tdata;
   logic [N_REQ-1:0] s_tvalid;
   logic [N_REQ-1:0] s_tlast;
   logic [N_REQ-1:0] s_tready;
   logic             corr_tdata;
   logic             corr_tvalid;
   logic             corr_tlast;
   logic             corr_tready;
   logic             res_tuser;
   logic             res_tvalid;
   logic             res_tready;
   logic             m_tuser;
   logic             m_terr;
   logic [IDW-1:0]   m_tid;
   logic             m_tvalid;
   logic             m_tready;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready,
      output corr_tdata, corr_tvalid, corr_tlast,
      input  corr_tready,
      input  res_tuser, res_tvalid,
      output res_tready,
      output m_tuser, m_terr, m_tid, m_tvalid,
      input  m_tready
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready,
      input  corr_tdata, corr_tvalid, corr_tlast,
      output corr_tready,
      output res_tuser, res_tvalid,
      input  res_tready,
      input  m_tuser, m_terr, m_tid, m_tvalid,
      output m_tready
   );
endinterface

// File: rtl/barker_corr_sched.sv
// Round-robin frame scheduler sharing one Barker correlator among N_REQ 1-bit streams,
// with overlength truncation and a result timeout.
module barker_corr_sched #(
   parameter int N_REQ   = 4,
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 16,
   parameter int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   barker_corr_sched_if.slave   bus,
   output logic                 o_busy,
   output logic                 o_overlen
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, XFER, DRAIN, WAIT_RES, DELIVER} state_t;

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] cand;
   logic           found;
   logic [CW-1:0]  beat_cnt;
   logic [TW-1:0]  to_cnt;
   logic           res_held;
   logic           res_bit;
   logic           res_err;
   logic           at_max;
   logic           to_hit;
   logic           beat_acc;
   logic           overlen_hit;

   // Search starts just past the last served requester so nobody is starved.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      cand   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IDW'((int'(rr_ptr) + i) % N_REQ);
         if (!found && bus.s_tvalid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_next      = state;
      bus.s_tready    = '0;
      bus.corr_tdata  = 1'b0;
      bus.corr_tvalid = 1'b0;
      bus.corr_tlast  = 1'b0;
      bus.res_tready  = 1'b0;
      bus.m_tvalid    = 1'b0;
      bus.m_tid       = '0;
      bus.m_tuser     = 1'b0;
      bus.m_terr      = 1'b0;
      at_max          = (beat_cnt == CW'(MAX_LEN - 1));
      to_hit          = (to_cnt == TW'(TIMEOUT - 1));
      beat_acc        = 1'b0;
      overlen_hit     = 1'b0;
      case (state)
         IDLE: begin
            if (found) state_next = XFER;
         end
         XFER: begin
            bus.corr_tdata         = bus.s_tdata[grant];
            bus.corr_tvalid        = bus.s_tvalid[grant];
            bus.corr_tlast         = bus.s_tlast[grant] | at_max;
            bus.s_tready[grant]    = bus.corr_tready;
            bus.res_tready         = 1'b1;
            beat_acc               = bus.s_tvalid[grant] & bus.corr_tready;
            if (beat_acc) begin
               if (bus.s_tlast[grant]) begin
                  state_next = WAIT_RES;
               end else if (at_max) begin
                  overlen_hit = 1'b1;
                  state_next  = DRAIN;
               end
            end
         end
         DRAIN: begin
            bus.s_tready[grant] = 1'b1;
            bus.res_tready      = 1'b1;
            // The truncated frame's result may already be in hand when the tail ends.
            if (bus.s_tvalid[grant] && bus.s_tlast[grant])
               state_next = (res_held || bus.res_tvalid) ? DELIVER : WAIT_RES;
         end
         WAIT_RES: begin
            bus.res_tready = 1'b1;
            if (bus.res_tvalid || to_hit) state_next = DELIVER;
         end
         DELIVER: begin
            bus.m_tvalid = 1'b1;
            bus.m_tid    = grant;
            bus.m_tuser  = res_bit;
            bus.m_terr   = res_err;
            if (bus.m_tready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= IDW'(N_REQ - 1);
         beat_cnt  <= '0;
         to_cnt    <= '0;
         res_held  <= 1'b0;
         res_bit   <= 1'b0;
         res_err   <= 1'b0;
         o_busy    <= 1'b0;
         o_overlen <= 1'b0;
      end else begin
         state     <= state_next;
         o_busy    <= (state_next != IDLE);
         o_overlen <= overlen_hit;
         case (state)
            IDLE: begin
               if (found) grant <= winner;
               beat_cnt <= '0;
               to_cnt   <= '0;
               res_held <= 1'b0;
            end
            XFER: begin
               if (beat_acc) beat_cnt <= beat_cnt + CW'(1);
            end
            DRAIN: begin
               if (bus.res_tvalid && !res_held) begin
                  res_held <= 1'b1;
                  res_bit  <= bus.res_tuser;
                  res_err  <= 1'b0;
               end
            end
            WAIT_RES: begin
               if (bus.res_tvalid) begin
                  res_bit <= bus.res_tuser;
                  res_err <= 1'b0;
               end else if (to_hit) begin
                  res_bit <= 1'b0;
                  res_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            DELIVER: begin
               if (bus.m_tready) begin
                  rr_ptr   <= grant;
                  beat_cnt <= '0;
                  to_cnt   <= '0;
                  res_held <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_barker_corr_sched.sv
// Directed bench for barker_corr_sched: a behavioural 2-cycle Barker-11 correlator sits
// behind the scheduler while the initial block plays requesters and the result sink.
module tb_barker_corr_sched;

   localparam int N_REQ   = 4;
   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 16;
   localparam int IDW     = 2;
   localparam logic [10:0] BARKER = 11'b11100010010;

   logic clk;
   logic rst_n;
   logic busy;
   logic overlen;
   logic res_block;
   int   errors;
   int   checks;
   int   overlen_cnt;

   barker_corr_sched_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

   barker_corr_sched #(
      .N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .IDW(IDW)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus.slave),
      .o_busy(busy),
      .o_overlen(overlen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Correlator stand-in: always ready, result two cycles after the tlast beat.
   logic [10:0] sr;
   logic        st1_v, st1_b, st2_v, st2_b;
   assign bus.corr_tready = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr             <= '0;
         st1_v          <= 1'b0;
         st1_b          <= 1'b0;
         st2_v          <= 1'b0;
         st2_b          <= 1'b0;
         bus.res_tvalid <= 1'b0;
         bus.res_tuser  <= 1'b0;
      end else begin
         st1_v <= 1'b0;
         if (bus.corr_tvalid && bus.corr_tready) begin
            sr <= {sr[9:0], bus.corr_tdata};
            if (bus.corr_tlast) begin
               st1_v <= 1'b1;
               st1_b <= ({sr[9:0], bus.corr_tdata} == BARKER);
            end
         end
         st2_v <= st1_v;
         st2_b <= st1_b;
         if (bus.res_tvalid && bus.res_tready) bus.res_tvalid <= 1'b0;
         if (st2_v && !res_block) begin
            bus.res_tvalid <= 1'b1;
            bus.res_tuser  <= st2_b;
         end
      end
   end

   initial overlen_cnt = 0;
   always @(negedge clk) if (overlen === 1'b1) overlen_cnt++;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one beat on requester r, waits for it to be taken and reports what the
   // correlator side saw for that beat.
   task automatic applyStimulus(input logic [1:0] r, input logic b, input logic last,
                                output logic fwd_valid, output logic fwd_last);
      int n;
      bus.s_tvalid[r] = 1'b1;
      bus.s_tdata[r]  = b;
      bus.s_tlast[r]  = last;
      #1;
      n = 0;
      while (bus.s_tready[r] !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) checkOutput("ready_wait", 32'd0, 32'd1);
      fwd_valid = bus.corr_tvalid;
      fwd_last  = bus.corr_tlast;
      @(posedge clk);
      #1;
      bus.s_tvalid[r] = 1'b0;
      bus.s_tlast[r]  = 1'b0;
   endtask

   task automatic sendFrame(input logic [1:0] r, input logic [31:0] bits, input int len,
                            output int first_last, output int dropped);
      logic fv, fl;
      first_last = 0;
      dropped    = 0;
      for (int i = 0; i < len; i++) begin
         applyStimulus(r, bits[5'(len - 1 - i)], (i == len - 1), fv, fl);
         if (!fv) dropped++;
         if (fl && first_last == 0) first_last = i + 1;
      end
   endtask

   task automatic waitResult(output int cyc);
      cyc = 0;
      while (bus.m_tvalid !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 200) checkOutput("result_wait", 32'd0, 32'd1);
   endtask

   function automatic logic [16:0] allOutputs();
      return {bus.s_tready, bus.corr_tdata, bus.corr_tvalid, bus.corr_tlast, bus.res_tready,
              bus.m_tuser, bus.m_terr, bus.m_tid, bus.m_tvalid, busy, overlen};
   endfunction

   initial begin
      int fl, dr, cyc, ov0;
      logic fv, flst, seen;
      logic [1:0] rr_exp [4];
      rr_exp = '{2'd0, 2'd2, 2'd0, 2'd2};
      errors = 0;
      checks = 0;
      res_block    = 1'b0;
      bus.s_tvalid = '0;
      bus.s_tdata  = '0;
      bus.s_tlast  = '0;
      bus.m_tready = 1'b1;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Matching frame from requester 0.
      sendFrame(2'd0, 32'(BARKER), 11, fl, dr);
      waitResult(cyc);
      checkOutput("match_latency", cyc, 3);
      checkOutput("match_tid", 32'(bus.m_tid), 0);
      checkOutput("match_tuser", 32'(bus.m_tuser), 1);
      checkOutput("match_terr", 32'(bus.m_terr), 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("idle_after", {30'd0, busy, bus.m_tvalid}, 0);

      // Non-matching frame from requester 1.
      sendFrame(2'd1, 32'(11'b11100010011), 11, fl, dr);
      waitResult(cyc);
      checkOutput("nomatch_tid", 32'(bus.m_tid), 1);
      checkOutput("nomatch_tuser", 32'(bus.m_tuser), 0);
      checkOutput("nomatch_terr", 32'(bus.m_terr), 0);
      @(posedge clk); #1;

      // 20-beat frame: 16 forwarded (5 zeros + Barker), 4 drained.
      ov0 = overlen_cnt;
      sendFrame(2'd3, 32'(20'b00000111000100101111), 20, fl, dr);
      checkOutput("overlen_last_beat", fl, 16);
      checkOutput("overlen_dropped", dr, 4);
      waitResult(cyc);
      checkOutput("overlen_tid", 32'(bus.m_tid), 3);
      checkOutput("overlen_tuser", 32'(bus.m_tuser), 1);
      checkOutput("overlen_terr", 32'(bus.m_terr), 0);
      checkOutput("overlen_pulses", overlen_cnt - ov0, 1);
      @(posedge clk); #1;

      // Correlator silent: timeout result.
      res_block = 1'b1;
      sendFrame(2'd2, 32'(BARKER), 11, fl, dr);
      waitResult(cyc);
      checkOutput("timeout_latency", cyc, TIMEOUT);
      checkOutput("timeout_terr", 32'(bus.m_terr), 1);
      checkOutput("timeout_tuser", 32'(bus.m_tuser), 0);
      checkOutput("timeout_tid", 32'(bus.m_tid), 2);
      @(posedge clk); #1;
      res_block = 1'b0;

      // Downstream backpressure while another requester is pending.
      bus.m_tready = 1'b0;
      sendFrame(2'd1, 32'(BARKER), 11, fl, dr);
      waitResult(cyc);
      bus.s_tvalid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput("bp_hold", {23'd0, bus.m_tvalid, bus.m_tid, bus.m_tuser, bus.m_terr, bus.s_tready},
                     {23'd0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000});
      end
      bus.s_tvalid[0] = 1'b0;
      bus.m_tready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_release", 32'(bus.m_tvalid), 0);
      @(negedge clk);

      // Round-robin from reset with requesters 0 and 2 always valid.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.s_tvalid = 4'b0101;
      bus.s_tlast  = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         waitResult(cyc);
         checkOutput("rr_tid", 32'(bus.m_tid), 32'(rr_exp[k]));
         @(posedge clk); #1;
      end
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      @(negedge clk);

      // Reset in the middle of a forwarded frame.
      for (int i = 0; i < 5; i++) applyStimulus(2'd0, BARKER[5'(10 - i)], 1'b0, fv, flst);
      bus.s_tvalid[0] = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_outputs", 32'(allOutputs()), 32'd0);
      bus.s_tvalid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.m_tvalid === 1'b1) seen = 1'b1;
      end
      checkOutput("rst_no_result", 32'(seen), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
